dbus_uart_tx: RTL and testbench

DBUS_UART_TX -- requirements
Module: dbus_uart_tx

---
 rtl/dbus_uart_tx_pkg.sv | 23 ++
 rtl/dbus_uart_tx_fifo.sv | 63 ++++++
 rtl/dbus_uart_tx.sv | 187 ++++++++++++++++++
 tb/tb_dbus_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_uart_tx_pkg.sv
// Shared definitions for the bus-mapped UART transmitter: register map,
// STATUS/CTRL bit positions and transmit FSM state encoding.
package dbus_uart_tx_pkg;

    localparam logic [3:0] REG_DATA   = 4'd0;
    localparam logic [3:0] REG_STATUS = 4'd1;
    localparam logic [3:0] REG_CTRL   = 4'd2;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 4;

    localparam int CTRL_IRQ_EN_BIT  = 0;
    localparam int CTRL_OVF_CLR_BIT = 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

endpackage

// File: rtl/dbus_uart_tx_fifo.sv
// Small synchronous FIFO with first-word-fall-through head output; a push
// while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Head is read combinationally so the consumer can pop and use it on one edge.
    assign o_dout = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dbus_uart_tx.sv
// Data-bus mapped UART transmitter: DATA/STATUS/CTRL registers, a transmit
// FIFO and an 8N1 serializer with a level interrupt on drained-and-idle.
module dbus_uart_tx
    import dbus_uart_tx_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hF000,
    parameter int          CLKS_PER_BIT = 139,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] dbus_addr,
    input  logic [31:0] dbus_write,
    input  logic        dbus_wen,
    output logic [31:0] dbus_read,
    output logic        tx,
    output logic        irq
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(CLKS_PER_BIT - 1);

    logic [1:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_irq;
    logic               r_irq_en;
    logic               r_overflow;
    logic [31:0]        r_dbus_read;

    logic [15:0]        w_offset;
    logic               w_sel;
    logic [3:0]         w_reg;
    logic               w_push;
    logic               w_ctrl_wr;
    logic               w_pop;
    logic               w_busy;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [4:0]         w_count_ext;
    logic [7:0]         w_fifo_dout;
    logic [31:0]        w_status;
    logic [31:0]        w_rd_data;
    logic               w_unused;

    // Subtracting the base makes the window check independent of base alignment.
    assign w_offset    = dbus_addr - BASE_ADDR;
    assign w_sel       = (w_offset[15:4] == 12'd0);
    assign w_reg       = w_offset[3:0];
    assign w_push      = ~rst & dbus_wen & w_sel & (w_reg == REG_DATA);
    assign w_ctrl_wr   = ~rst & dbus_wen & w_sel & (w_reg == REG_CTRL);
    assign w_busy      = (r_state != S_IDLE);
    assign w_pop       = ~rst & ~w_empty &
                         ((r_state == S_IDLE) | ((r_state == S_STOP) & (r_timer == '0)));
    assign w_count_ext = 5'(w_count);
    assign w_unused    = ^{dbus_write[31:8], w_count_ext[4]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (dbus_write[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status                           = '0;
        w_status[ST_FULL_BIT]              = w_full;
        w_status[ST_EMPTY_BIT]             = w_empty;
        w_status[ST_BUSY_BIT]              = w_busy;
        w_status[ST_OVF_BIT]               = r_overflow;
        w_status[ST_COUNT_LSB +: 4]        = w_count_ext[3:0];
    end

    always_comb begin
        w_rd_data = '0;
        if (w_sel) begin
            case (w_reg)
                REG_STATUS: w_rd_data = w_status;
                REG_CTRL:   w_rd_data[CTRL_IRQ_EN_BIT] = r_irq_en;
                default:    w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbus_read <= '0;
            r_irq_en    <= 1'b0;
            r_overflow  <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_dbus_read <= w_rd_data;
            r_irq       <= r_irq_en & w_empty & ~w_busy;
            if (w_ctrl_wr) begin
                r_irq_en <= dbus_write[CTRL_IRQ_EN_BIT];
            end
            if (w_ctrl_wr & dbus_write[CTRL_OVF_CLR_BIT]) begin
                r_overflow <= 1'b0;
            end else if (w_push & w_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_timer   <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= w_fifo_dout;
                        r_tx    <= 1'b0;
                        r_timer <= TIMER_LOAD;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_timer == '0) begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_timer <= TIMER_LOAD;
                        r_state <= S_DATA;
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_timer == '0) begin
                        r_timer <= TIMER_LOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            r_tx      <= 1'b1;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_timer == '0) begin
                        // Chain straight into the next start bit when more data is queued.
                        if (w_pop) begin
                            r_shift <= w_fifo_dout;
                            r_tx    <= 1'b0;
                            r_timer <= TIMER_LOAD;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_timer <= r_timer - TIMER_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign dbus_read = r_dbus_read;
    assign tx        = r_tx;
    assign irq       = r_irq;

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Randomized scoreboard bench for dbus_uart_tx: a frame-level reference model
// predicts bus reads, irq and the serial waveform; a UART receiver decodes tx.
module tb_dbus_uart_tx;

    localparam logic [15:0] BASE  = 16'hF000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
    localparam int          FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dbus_addr;
    logic [31:0] dbus_write;
    logic        dbus_wen;
    logic [31:0] dbus_read;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dbus_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dbus_addr  (dbus_addr),
        .dbus_write (dbus_write),
        .dbus_wen   (dbus_wen),
        .dbus_read  (dbus_read),
        .tx         (tx),
        .irq        (irq)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (frame-level timing) ----------------
    logic [7:0]  m_fifo[$];
    logic [7:0]  exp_bytes[$];
    logic [31:0] rd_q[$];
    bit          m_active = 1'b0;
    int          m_start  = 0;
    logic [7:0]  m_cur    = 8'd0;
    bit          m_ovf    = 1'b0;
    bit          m_irq_en = 1'b0;
    logic        exp_tx   = 1'b1;
    logic        exp_irq  = 1'b0;
    bit          model_valid = 1'b0;
    bit          rx_abort = 1'b0;
    int          cyc = 0;

    always @(posedge clk) begin : model
        logic [15:0] off;
        logic [31:0] rdv;
        bit          busy_pre;
        bit          empty_pre;
        bit          full_pre;
        int          cnt_pre;
        int          k;
        cyc++;
        off = dbus_addr - BASE;
        if (rst) begin
            m_fifo.delete();
            exp_bytes.delete();
            m_active    = 1'b0;
            m_ovf       = 1'b0;
            m_irq_en    = 1'b0;
            exp_tx      = 1'b1;
            exp_irq     = 1'b0;
            rx_abort    = 1'b1;
            if (model_valid) rd_q.push_back(32'h0);
            model_valid = 1'b1;
        end else if (model_valid) begin
            cnt_pre   = m_fifo.size();
            busy_pre  = m_active;
            empty_pre = (cnt_pre == 0);
            full_pre  = (cnt_pre == DEPTH);
            rdv = 32'h0;
            if (off < 16) begin
                if (off == 16'd1)
                    rdv = {24'b0, 4'(cnt_pre), m_ovf, busy_pre, empty_pre, full_pre};
                else if (off == 16'd2)
                    rdv = {31'b0, m_irq_en};
            end
            rd_q.push_back(rdv);
            exp_irq = m_irq_en & empty_pre & ~busy_pre;
            if (m_active && cyc >= m_start + FRAME) m_active = 1'b0;
            if (!m_active && m_fifo.size() > 0) begin
                m_cur    = m_fifo.pop_front();
                m_start  = cyc;
                m_active = 1'b1;
                exp_bytes.push_back(m_cur);
            end
            if (dbus_wen && off < 16) begin
                if (off == 16'd0) begin
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(dbus_write[7:0]);
                    else m_ovf = 1'b1;
                end else if (off == 16'd2) begin
                    m_irq_en = dbus_write[0];
                    if (dbus_write[1]) m_ovf = 1'b0;
                end
            end
            if (m_active) begin
                k = (cyc - m_start) / CPB;
                if (k == 0)      exp_tx = 1'b0;
                else if (k <= 8) exp_tx = m_cur[k-1];
                else             exp_tx = 1'b1;
            end else begin
                exp_tx = 1'b1;
            end
        end
    end

    // ---------------- monitor: compares every presented output ----------------
    always @(negedge clk) begin : monitor
        logic [31:0] r;
        if (model_valid) begin
            chk("tx", 32'(tx), 32'(exp_tx));
            chk("irq", 32'(irq), 32'(exp_irq));
            if (rd_q.size() > 0) begin
                r = rd_q.pop_front();
                chk("dbus_read", dbus_read, r);
            end
        end
    end

    // ---------------- serial receiver: decodes frames, pops scoreboard ----------------
    int         rx_cnt = -1;
    logic [7:0] rx_byte = 8'd0;

    always @(negedge clk) begin : receiver
        int bi;
        logic [7:0] e;
        if (rx_abort) begin
            rx_cnt   = -1;
            rx_abort = 1'b0;
        end else if (model_valid) begin
            if (rx_cnt < 0) begin
                if (tx === 1'b0) rx_cnt = 0;
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == CPB / 2) begin
                    bi = rx_cnt / CPB;
                    if (bi == 0) begin
                        chk("rx_start", 32'(tx), 32'h0);
                    end else if (bi <= 8) begin
                        rx_byte[bi-1] = tx;
                    end else begin
                        chk("rx_stop", 32'(tx), 32'h1);
                        if (exp_bytes.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_unexpected: got frame %02h expected none", rx_byte);
                        end else begin
                            e = exp_bytes.pop_front();
                            chk("rx_byte", 32'(rx_byte), 32'(e));
                            $display("frame rx %02h (expected %02h)", rx_byte, e);
                        end
                        rx_cnt = -1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        dbus_addr  = a;
        dbus_write = d;
        dbus_wen   = 1'b1;
        @(negedge clk);
        dbus_wen   = 1'b0;
        dbus_addr  = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a);
        dbus_addr = a;
        dbus_wen  = 1'b0;
        @(negedge clk);
        dbus_addr = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        dbus_addr  = 16'h0000;
        dbus_write = 32'h0;
        dbus_wen   = 1'b0;
        idle(3);
        rst = 1'b0;
        rd(BASE + 16'd1);

        // single frame then STATUS
        wr(BASE, 32'hFFFF_FF55);
        idle(45);
        rd(BASE + 16'd1);

        // back-to-back frames
        wr(BASE, 32'h41);
        wr(BASE, 32'h42);
        idle(90);

        // fill to full, overflow, clear
        for (int i = 0; i < 9; i++) begin
            wr(BASE, 32'(8'h10 + i));
            rd(BASE + 16'd1);
        end
        wr(BASE, 32'hEE);
        rd(BASE + 16'd1);
        wr(BASE + 16'd2, 32'h2);
        rd(BASE + 16'd1);
        rd(BASE + 16'd2);
        idle(FRAME * (DEPTH + 2));

        // interrupt enable around one frame
        wr(BASE + 16'd2, 32'h1);
        rd(BASE + 16'd2);
        wr(BASE, 32'h3C);
        idle(50);
        wr(BASE + 16'd2, 32'h0);
        idle(5);

        // reset during data bit 3
        wr(BASE, 32'hA5);
        idle(17);
        pulse_rst();
        rd(BASE + 16'd1);
        idle(50);

        // address decode edges and reserved offsets
        rd(BASE - 16'd1);
        rd(BASE + 16'd16);
        rd(BASE + 16'd1);
        wr(BASE + 16'd5, 32'hFFFF_FFFF);
        wr(BASE - 16'd1, 32'h12);
        wr(BASE + 16'd16, 32'h34);
        rd(BASE + 16'd5);
        rd(BASE + 16'd2);
        idle(5);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            if ($urandom_range(0, 599) == 0) begin
                pulse_rst();
            end else begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1, 2, 3: dbus_addr = BASE;
                    4:          dbus_addr = BASE + 16'd1;
                    5:          dbus_addr = BASE + 16'd2;
                    6:          dbus_addr = BASE + 16'($urandom_range(3, 15));
                    7:          dbus_addr = BASE - 16'd1;
                    8:          dbus_addr = BASE + 16'd16;
                    default:    dbus_addr = 16'($urandom);
                endcase
                dbus_write = $urandom;
                dbus_wen   = ($urandom_range(0, (i < 1500) ? 3 : 9) == 0);
                @(negedge clk);
            end
        end
        dbus_wen  = 1'b0;
        dbus_addr = 16'h0000;
        idle(FRAME * (DEPTH + 2));

        chk("frames_pending", 32'(exp_bytes.size()), 32'h0);
        chk("rx_idle_at_end", 32'(rx_cnt), 32'hFFFF_FFFF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
